// File: rtl/pcm_pkg.sv
// Shared state encoding, volume width and sample arithmetic for the PCM player.
package pcm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DRAIN
    } pcm_state_t;

    localparam int unsigned VOL_W = 4;

    function automatic int unsigned pcm_mid(input int unsigned data_w);
        return 32'd1 << (data_w - 1);
    endfunction

    // Attenuate around the midpoint: MID + ((data - MID) * (vol + 1)) >>> VOL_W
    function automatic int unsigned pcm_scale(input int unsigned data,
                                              input logic [VOL_W-1:0] vol,
                                              input int unsigned data_w);
        int d;
        int p;
        d = int'(data) - int'(pcm_mid(data_w));
        p = d * (int'({1'b0, vol}) + 1);
        return $unsigned(int'(pcm_mid(data_w)) + (p >>> VOL_W));
    endfunction

endpackage

// File: rtl/pcm_pwm.sv
// Free-running PWM modulator: output is high while the counter is below level.
module pcm_pwm #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] level,
    output logic              pwm
);

    logic [DATA_W-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
            pwm <= 1'b0;
        end else begin
            cnt <= cnt + DATA_W'(1);
            pwm <= (cnt < level);
        end
    end

endmodule

// File: rtl/pcm_player.sv
// Single-channel PCM sample player: rate divider, sync memory fetch, volume, PWM.
// Define PCM_PLAYER_LOOP_EN to honour the loop input; otherwise playback is one-shot.
module pcm_player
    import pcm_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [DIV_W-1:0]  rate_div,
    input  logic [VOL_W-1:0]  volume,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] sample_o,
    output logic              busy,
    output logic              done,
    output logic              pwm
);

    localparam logic [DATA_W-1:0] MID = DATA_W'(pcm_mid(DATA_W));

    pcm_state_t        state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] idx;
    logic [DIV_W-1:0]  rate_q;
    logic [DIV_W-1:0]  div_cnt;
    logic              cap_pend;
    logic              tick;
    logic              last;
    logic [DIV_W-1:0]  rate_eff;
    logic [DATA_W-1:0] scaled;

`ifdef PCM_PLAYER_LOOP_EN
    logic              loop_q;
`else
    logic              unused_loop;
    assign unused_loop = loop;
`endif

    assign tick     = (div_cnt == rate_q);
    assign last     = (idx == len_q - ADDR_W'(1));
    assign rate_eff = (rate_div == '0) ? DIV_W'(1) : rate_div;
    assign scaled   = DATA_W'(pcm_scale(32'(mem_data), volume, DATA_W));

    // Strobe decoded from registered state so the first fetch lands the cycle after start
    assign mem_rd   = (state == PLAY) && tick;
    assign mem_addr = base_q + idx;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            idx      <= '0;
            rate_q   <= '0;
            div_cnt  <= '0;
            cap_pend <= 1'b0;
            sample_o <= MID;
            done     <= 1'b0;
`ifdef PCM_PLAYER_LOOP_EN
            loop_q   <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            cap_pend <= 1'b0;
            if (cap_pend) begin
                sample_o <= scaled;
            end
            unique case (state)
                IDLE: begin
                    if (start && !stop && (length != '0)) begin
                        base_q  <= base_addr;
                        len_q   <= length;
                        rate_q  <= rate_eff;
                        div_cnt <= rate_eff;
                        idx     <= '0;
`ifdef PCM_PLAYER_LOOP_EN
                        loop_q  <= loop;
`endif
                        state   <= PLAY;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state    <= IDLE;
                        div_cnt  <= '0;
                        sample_o <= MID;
                    end else begin
                        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                        if (tick) begin
                            cap_pend <= 1'b1;
                            if (last) begin
`ifdef PCM_PLAYER_LOOP_EN
                                if (loop_q) begin
                                    idx <= '0;
                                end else begin
                                    state <= DRAIN;
                                end
`else
                                state <= DRAIN;
`endif
                            end else begin
                                idx <= idx + ADDR_W'(1);
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (stop) begin
                        state    <= IDLE;
                        div_cnt  <= '0;
                        sample_o <= MID;
                    end else if (tick) begin
                        state    <= IDLE;
                        div_cnt  <= '0;
                        done     <= 1'b1;
                        sample_o <= MID;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    pcm_pwm #(
        .DATA_W(DATA_W)
    ) u_pwm (
        .clk  (clk),
        .rstn (rstn),
        .level(sample_o),
        .pwm  (pwm)
    );

endmodule

// File: tb/tb_pcm_player.sv
// Scoreboard bench for pcm_player: expected fetches, samples and done pulses are queued at start.
module tb_pcm_player;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIV_W  = 16;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] length = '0;
    logic [DIV_W-1:0]  rate_div = '0;
    logic [3:0]        volume = 4'hF;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data = '0;
    logic [DATA_W-1:0] sample_o;
    logic              busy;
    logic              done;
    logic              pwm;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] exp_smp_q[$];
    int unsigned       exp_done_q[$];

    int unsigned exp_period = 0;
    int unsigned exp_first = 0;
    int unsigned last_rd = 0;
    int unsigned rd_count = 0;
    bit          first_pend = 1'b0;
    bit          last_valid = 1'b0;
    bit          rd_d1 = 1'b0;
    bit          rd_d2 = 1'b0;

    pcm_player #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DIV_W (DIV_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .stop     (stop),
        .loop     (loop),
        .base_addr(base_addr),
        .length   (length),
        .rate_div (rate_div),
        .volume   (volume),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .sample_o (sample_o),
        .busy     (busy),
        .done     (done),
        .pwm      (pwm)
    );

    always #5 clk = ~clk;

    // Cycle counter and latency-1 synchronous memory returning the address low byte
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd) mem_data <= mem_addr[7:0];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_scale(input logic [7:0] s, input logic [3:0] v);
        int p;
        int q;
        p = (int'(s) - 128) * (int'(v) + 1);
        q = (p >= 0) ? p / 16 : -((-p + 15) / 16);
        return 8'(128 + q);
    endfunction

    always @(negedge clk) begin
        if (!rstn) begin
            rd_d1 = 1'b0;
            rd_d2 = 1'b0;
            last_valid = 1'b0;
        end else begin
            if (rd_d2 && exp_smp_q.size() != 0)
                check("sample", 32'(sample_o), 32'(exp_smp_q.pop_front()));
            rd_d2 = rd_d1;
            rd_d1 = mem_rd;
            if (mem_rd) begin
                rd_count++;
                if (exp_addr_q.size() == 0) check("unexp_rd", 32'(mem_rd), 32'd0);
                else check("addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
                if (first_pend) begin
                    check("first_rd_cyc", cyc, exp_first);
                    first_pend = 1'b0;
                end else if (last_valid) begin
                    check("rd_period", cyc - last_rd, exp_period);
                end
                last_rd = cyc;
                last_valid = 1'b1;
            end
            if (done) begin
                if (exp_done_q.size() == 0) check("unexp_done", 32'(done), 32'd0);
                else begin
                    check("done_cyc", cyc, exp_done_q.pop_front());
                    check("done_busy", 32'(busy), 32'd0);
                    check("done_mid", 32'(sample_o), 32'h80);
                end
            end
        end
    end

    task automatic play(input logic [15:0] b, input logic [15:0] n, input logic [15:0] r,
                        input logic [3:0] v, input bit lp, input int unsigned nf,
                        output int unsigned s);
        int unsigned per;
        bit          lp_eff;
        logic [15:0] a;
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        length = n;
        rate_div = r;
        volume = v;
        loop = lp;
        s = cyc;
`ifdef PCM_PLAYER_LOOP_EN
        lp_eff = lp;
`else
        lp_eff = 1'b0;
`endif
        per = (r == 0) ? 2 : int'(r) + 1;
        exp_period = per;
        exp_first = s + 1;
        first_pend = 1'b1;
        last_valid = 1'b0;
        for (int unsigned i = 0; i < nf; i++) begin
            a = 16'(b + 16'(i % int'(n)));
            exp_addr_q.push_back(a);
            exp_smp_q.push_back(ref_scale(a[7:0], v));
        end
        if (!lp_eff) exp_done_q.push_back(s + int'(n) * per + 2);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned max_cyc);
        for (int unsigned i = 0; i < max_cyc && busy; i++) @(negedge clk);
        check("idle_timeout", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("idle_mid", 32'(sample_o), 32'h80);
        check("pend_addr", exp_addr_q.size(), 32'd0);
        check("pend_smp", exp_smp_q.size(), 32'd0);
        check("pend_done", exp_done_q.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned s;
        int unsigned rd0;
        int          hi;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_sample", 32'(sample_o), 32'h80);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pwm", 32'(pwm), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // One-shot
        play(16'h0010, 16'd4, 16'd3, 4'hF, 1'b0, 4, s);
        wait_idle(100);

        // Loop with address wrap (one-shot when the loop feature is absent)
`ifdef PCM_PLAYER_LOOP_EN
        play(16'hFFFE, 16'd3, 16'd5, 4'hF, 1'b1, 7, s);
        while (cyc < s + 40) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_mid", 32'(sample_o), 32'h80);
        repeat (20) @(negedge clk);
        check("loop_pend_addr", exp_addr_q.size(), 32'd0);
        check("loop_busy", 32'(busy), 32'd0);
`else
        play(16'hFFFE, 16'd3, 16'd1, 4'hF, 1'b1, 3, s);
        wait_idle(50);
`endif

        // Volume scaling
        play(16'h0000, 16'd1, 16'd2, 4'd7, 1'b0, 1, s);
        wait_idle(50);
        play(16'h00FF, 16'd1, 16'd2, 4'd7, 1'b0, 1, s);
        wait_idle(50);
        play(16'h0090, 16'd1, 16'd0, 4'd0, 1'b0, 1, s);
        wait_idle(50);

        // start with length 0
        rd0 = rd_count;
        @(negedge clk);
        start = 1'b1; length = '0; base_addr = 16'h0055; rate_div = 16'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_rd", rd_count - rd0, 32'd0);

        // start and stop together while idle
        rd0 = rd_count;
        @(negedge clk);
        start = 1'b1; stop = 1'b1; length = 16'd4;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check("startstop_rd", rd_count - rd0, 32'd0);

        // start while busy is ignored
        play(16'h0020, 16'd2, 16'd3, 4'hF, 1'b0, 2, s);
        start = 1'b1; base_addr = 16'h0050; length = 16'd5; rate_div = 16'd0;
        @(negedge clk);
        start = 1'b0;
        wait_idle(100);

        // PWM duty at 0x40 and at 0x00
        play(16'h0040, 16'd1, 16'd600, 4'hF, 1'b0, 1, s);
        repeat (10) @(negedge clk);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (pwm) hi++;
        end
        check("pwm_0x40", hi, 32'd64);
        wait_idle(700);
        play(16'h0000, 16'd1, 16'd600, 4'hF, 1'b0, 1, s);
        repeat (10) @(negedge clk);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (pwm) hi++;
        end
        check("pwm_0x00", hi, 32'd0);
        wait_idle(700);

        // Asynchronous reset mid-PLAY
        play(16'h0030, 16'd4, 16'd3, 4'hF, 1'b0, 4, s);
        repeat (4) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_mem_rd", 32'(mem_rd), 32'd0);
        check("arst_mem_addr", 32'(mem_addr), 32'd0);
        check("arst_sample", 32'(sample_o), 32'h80);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_pwm", 32'(pwm), 32'd0);
        exp_addr_q.delete();
        exp_smp_q.delete();
        exp_done_q.delete();
        first_pend = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        play(16'h0010, 16'd4, 16'd3, 4'hF, 1'b0, 4, s);
        wait_idle(100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
